// File: rtl/gpr_writeback_queue.sv
// gpr_writeback_queue
//
// Buffers destination-register results from the LSU and the ALU and drains
// them into the register file's single write port at one write per cycle.
// Operand fetch uses o_pending_A/B to stall on read-after-write hazards until
// the queued result has been written.
//
// Ports:
//   i_clk, i_rst_n        clock (posedge), asynchronous active-low reset
//   i_flush               synchronous clear of all queued entries
//   i_lsu_*/o_lsu_ready   LSU result handshake (older instruction, enqueued first)
//   i_alu_*/o_alu_ready   ALU result handshake (one slot always kept for the LSU)
//   o_load_gpr*           registered register-file write strobe/select/data
//   i_check_A/B_sel       operand selects checked for pending writes
//   o_pending_A/B         a write to that register is queued or being written
//   o_count               number of occupied entries
module gpr_writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_lsu_valid,
    output logic                     o_lsu_ready,
    input  logic [4:0]               i_lsu_sel,
    input  logic [31:0]              i_lsu_data,
    input  logic                     i_alu_valid,
    output logic                     o_alu_ready,
    input  logic [4:0]               i_alu_sel,
    input  logic [31:0]              i_alu_data,
    output logic                     o_load_gpr,
    output logic [4:0]               o_load_gpr_sel,
    output logic [31:0]              o_load_gpr_data,
    input  logic [4:0]               i_check_A_sel,
    input  logic [4:0]               i_check_B_sel,
    output logic                     o_pending_A,
    output logic                     o_pending_B,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] ALU_LIMIT = CW'(DEPTH - 1);

    logic [4:0]    sel_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] alu_slot;
    logic          lsu_push;
    logic          alu_push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [DEPTH-1:0] occupied;

    // Ready depends only on the registered count. Keeping the ALU one slot
    // short means two enqueues plus the pop can never overflow.
    assign o_lsu_ready = (o_count < FULL_CNT);
    assign o_alu_ready = (o_count < ALU_LIMIT);

    // Handshakes to r0 complete but store nothing; flush discards everything.
    assign lsu_push = i_lsu_valid & o_lsu_ready & (i_lsu_sel != '0) & ~i_flush;
    assign alu_push = i_alu_valid & o_alu_ready & (i_alu_sel != '0) & ~i_flush;
    assign pop      = (o_count != '0);

    // ALU entry lands behind the LSU entry when both push in one cycle.
    assign alu_slot   = tail + AW'(lsu_push);
    assign count_next = o_count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);

    // Storage is not reset; only occupied entries are ever observed.
    always_ff @(posedge i_clk) begin
        if (lsu_push) begin
            sel_mem[tail]  <= i_lsu_sel;
            data_mem[tail] <= i_lsu_data;
        end
        if (alu_push) begin
            sel_mem[alu_slot]  <= i_alu_sel;
            data_mem[alu_slot] <= i_alu_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count         <= '0;
            head            <= '0;
            tail            <= '0;
            o_load_gpr      <= 1'b0;
            o_load_gpr_sel  <= '0;
            o_load_gpr_data <= '0;
        end else if (i_flush) begin
            o_count    <= '0;
            head       <= '0;
            tail       <= '0;
            o_load_gpr <= 1'b0;
        end else begin
            o_count <= count_next;
            tail    <= tail + AW'(lsu_push) + AW'(alu_push);
            if (pop) begin
                o_load_gpr      <= 1'b1;
                o_load_gpr_sel  <= sel_mem[head];
                o_load_gpr_data <= data_mem[head];
                head            <= head + AW'(1);
            end else begin
                o_load_gpr <= 1'b0;
            end
        end
    end

    // An entry is occupied when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occupied = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, AW'(i) - head} < o_count);
        end
    end

    always_comb begin
        o_pending_A = o_load_gpr && (o_load_gpr_sel == i_check_A_sel);
        o_pending_B = o_load_gpr && (o_load_gpr_sel == i_check_B_sel);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (sel_mem[i] == i_check_A_sel)) o_pending_A = 1'b1;
            if (occupied[i] && (sel_mem[i] == i_check_B_sel)) o_pending_B = 1'b1;
        end
        if (i_check_A_sel == '0) o_pending_A = 1'b0;
        if (i_check_B_sel == '0) o_pending_B = 1'b0;
    end

endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Self-checking bench for gpr_writeback_queue. Accepted entries are pushed to
// a scoreboard when driven; the write-port monitor pops and compares them.
module tb_gpr_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_lsu_valid = 1'b0;
    logic        o_lsu_ready;
    logic [4:0]  i_lsu_sel = '0;
    logic [31:0] i_lsu_data = '0;
    logic        i_alu_valid = 1'b0;
    logic        o_alu_ready;
    logic [4:0]  i_alu_sel = '0;
    logic [31:0] i_alu_data = '0;
    logic        o_load_gpr;
    logic [4:0]  o_load_gpr_sel;
    logic [31:0] o_load_gpr_data;
    logic [4:0]  i_check_A_sel = '0;
    logic [4:0]  i_check_B_sel = '0;
    logic        o_pending_A;
    logic        o_pending_B;
    logic [2:0]  o_count;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   m_count = 0;

    always #5 i_clk = ~i_clk;

    gpr_writeback_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
        .i_lsu_sel(i_lsu_sel), .i_lsu_data(i_lsu_data),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_sel(i_alu_sel), .i_alu_data(i_alu_data),
        .o_load_gpr(o_load_gpr), .o_load_gpr_sel(o_load_gpr_sel),
        .o_load_gpr_data(o_load_gpr_data),
        .i_check_A_sel(i_check_A_sel), .i_check_B_sel(i_check_B_sel),
        .o_pending_A(o_pending_A), .o_pending_B(o_pending_B),
        .o_count(o_count)
    );

    // Write-port monitor: every write must be the oldest expected entry.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_load_gpr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got sel=%0d data=%h, expected no write",
                         o_load_gpr_sel, o_load_gpr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_load_gpr_sel !== mon_e.sel || o_load_gpr_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_order: got sel=%0d data=%h, expected sel=%0d data=%h",
                             o_load_gpr_sel, o_load_gpr_data, mon_e.sel, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus starting at a negedge; returns at the next negedge.
    // The model decides acceptance from its own count, not from DUT ready.
    task automatic drive(input logic lv, input logic [4:0] ls, input logic [31:0] ld,
                         input logic av, input logic [4:0] asel, input logic [31:0] ad,
                         input logic fl);
        int enq;
        i_lsu_valid = lv; i_lsu_sel = ls; i_lsu_data = ld;
        i_alu_valid = av; i_alu_sel = asel; i_alu_data = ad;
        i_flush = fl;
        #1;
        enq = 0;
        if (fl) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (lv && m_count < int'(DEPTH) && ls != 0) begin
                exp_q.push_back(ent_t'({ls, ld})); enq++;
            end
            if (av && m_count < int'(DEPTH) - 1 && asel != 0) begin
                exp_q.push_back(ent_t'({asel, ad})); enq++;
            end
            m_count = m_count + enq - ((m_count > 0) ? 1 : 0);
        end
        @(negedge i_clk);
        i_lsu_valid = 1'b0; i_alu_valid = 1'b0; i_flush = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            #1;
            if (exp_q.size() == 0 && m_count == 0) break;
            idle();
        end
    endtask

    task automatic test_reset();
        i_check_A_sel = 5'd5; i_check_B_sel = 5'd6;
        #12;
        checks++; if (o_load_gpr !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", o_load_gpr); end
        checks++; if (o_load_gpr_sel !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", o_load_gpr_sel); end
        checks++; if (o_load_gpr_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_load_gpr_data); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        checks++; if (o_lsu_ready !== 1'b1 || o_alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got lsu=%b alu=%b expected 1 1", o_lsu_ready, o_alu_ready); end
        checks++; if (o_pending_A !== 1'b0 || o_pending_B !== 1'b0) begin errors++; $display("FAIL reset_pending: got A=%b B=%b expected 0 0", o_pending_A, o_pending_B); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_q.delete(); m_count = 0;
    endtask

    task automatic test_latency();
        i_check_A_sel = 5'd5; i_check_B_sel = 5'd6;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        checks++; if (o_count !== 3'd1 || o_load_gpr !== 1'b0) begin errors++; $display("FAIL lat_accept: got count=%0d load=%b expected 1 0", o_count, o_load_gpr); end
        checks++; if (o_pending_A !== 1'b1 || o_pending_B !== 1'b0) begin errors++; $display("FAIL lat_pend_queued: got A=%b B=%b expected 1 0", o_pending_A, o_pending_B); end
        idle();
        checks++; if (o_load_gpr !== 1'b1 || o_load_gpr_sel !== 5'd5 || o_load_gpr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_write: got load=%b sel=%0d data=%h expected 1 5 deadbeef", o_load_gpr, o_load_gpr_sel, o_load_gpr_data); end
        checks++; if (o_pending_A !== 1'b1 || o_count !== 3'd0) begin errors++; $display("FAIL lat_pend_writing: got A=%b count=%0d expected 1 0", o_pending_A, o_count); end
        idle();
        checks++; if (o_load_gpr !== 1'b0 || o_pending_A !== 1'b0) begin errors++; $display("FAIL lat_done: got load=%b A=%b expected 0 0", o_load_gpr, o_pending_A); end
    endtask

    task automatic test_same_cycle();
        i_check_A_sel = 5'd3;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 1'b0);
        checks++; if (o_count !== 3'd2 || o_pending_A !== 1'b1) begin errors++; $display("FAIL dual_accept: got count=%0d A=%b expected 2 1", o_count, o_pending_A); end
        idle();
        checks++; if (o_count !== 3'd1 || o_load_gpr_data !== 32'h1) begin errors++; $display("FAIL dual_first: got count=%0d data=%h expected 1 1", o_count, o_load_gpr_data); end
        idle();
        checks++; if (o_count !== 3'd0 || o_load_gpr_data !== 32'h2 || o_pending_A !== 1'b1) begin errors++; $display("FAIL dual_second: got count=%0d data=%h A=%b expected 0 2 1", o_count, o_load_gpr_data, o_pending_A); end
        idle();
        checks++; if (o_load_gpr !== 1'b0 || o_pending_A !== 1'b0) begin errors++; $display("FAIL dual_done: got load=%b A=%b expected 0 0", o_load_gpr, o_pending_A); end
    endtask

    task automatic test_sel_zero();
        i_check_A_sel = 5'd0; i_check_B_sel = 5'd7;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b expected 1", o_alu_ready); end
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
        checks++; if (o_count !== 3'd0 || o_pending_A !== 1'b0) begin errors++; $display("FAIL r0_discard: got count=%0d A=%b expected 0 0", o_count, o_pending_A); end
        idle();
        checks++; if (o_load_gpr !== 1'b0) begin errors++; $display("FAIL r0_no_write: got load=%b expected 0", o_load_gpr); end
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77, 1'b0);
        checks++; if (o_count !== 3'd1 || o_pending_B !== 1'b1) begin errors++; $display("FAIL r0_lsu_alu: got count=%0d B=%b expected 1 1", o_count, o_pending_B); end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL r0_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic saw_block;
        saw_block = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 5'((2 * k) % 31 + 1), {16'hA000, 16'(k)},
                  1'b1, 5'((2 * k + 1) % 31 + 1), {16'hB000, 16'(k)}, 1'b0);
            checks++; if (o_count !== 3'(m_count) || o_count > 3'(DEPTH)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, o_count, m_count); end
            checks++; if (o_alu_ready !== (m_count < int'(DEPTH) - 1) || o_lsu_ready !== (m_count < int'(DEPTH))) begin errors++; $display("FAIL b2b_ready[%0d]: got lsu=%b alu=%b at model count %0d", k, o_lsu_ready, o_alu_ready, m_count); end
            if (m_count == 3 && o_alu_ready === 1'b0) saw_block = 1'b1;
        end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_alu_block: got %b expected 1", saw_block); end
        drain();
        checks++; if (exp_q.size() != 0 || o_count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d left count=%0d expected 0 0", exp_q.size(), o_count); end
        // Single-source stream: never stalls, count stays at 1.
        for (int k = 0; k < 8; k++) begin
            checks++; if (o_lsu_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, o_lsu_ready); end
            drive(1'b1, 5'(k + 20), {16'hC000, 16'(k)}, 1'b0, '0, '0, 1'b0);
        end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL stream_count: got %0d expected 1", o_count); end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        i_check_A_sel = 5'd9; i_check_B_sel = 5'd12;
        idle();
        drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 1'b0);
        drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b0);
        checks++; if (o_count !== 3'd3 || o_pending_B !== 1'b1) begin errors++; $display("FAIL flush_fill: got count=%0d B=%b expected 3 1", o_count, o_pending_B); end
        drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b1);
        checks++; if (o_count !== 3'd0 || o_load_gpr !== 1'b0) begin errors++; $display("FAIL flush_clear: got count=%0d load=%b expected 0 0", o_count, o_load_gpr); end
        checks++; if (o_pending_A !== 1'b0 || o_pending_B !== 1'b0) begin errors++; $display("FAIL flush_pending: got A=%b B=%b expected 0 0", o_pending_A, o_pending_B); end
        for (int k = 0; k < 3; k++) begin
            idle();
            checks++; if (o_load_gpr !== 1'b0 || o_count !== 3'd0) begin errors++; $display("FAIL flush_quiet[%0d]: got load=%b count=%0d expected 0 0", k, o_load_gpr, o_count); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15, 1'b0);
        drive(1'b1, 5'd16, 32'h16, 1'b0, '0, '0, 1'b0);
        checks++; if (o_count !== 3'd2 || o_load_gpr !== 1'b1) begin errors++; $display("FAIL arst_pre: got count=%0d load=%b expected 2 1", o_count, o_load_gpr); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_load_gpr !== 1'b0 || o_load_gpr_sel !== 5'd0 || o_load_gpr_data !== 32'd0) begin errors++; $display("FAIL arst_out: got load=%b sel=%0d data=%h expected 0 0 0", o_load_gpr, o_load_gpr_sel, o_load_gpr_data); end
        checks++; if (o_count !== 3'd0 || o_lsu_ready !== 1'b1) begin errors++; $display("FAIL arst_count: got count=%0d lsu_ready=%b expected 0 1", o_count, o_lsu_ready); end
        exp_q.delete(); m_count = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle();
            checks++; if (o_load_gpr !== 1'b0 || o_count !== 3'd0) begin errors++; $display("FAIL arst_after[%0d]: got load=%b count=%0d expected 0 0", k, o_load_gpr, o_count); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_same_cycle();
        test_sel_zero();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
